serial_out_16b: RTL and testbench

SERIAL_OUT_16B -- requirements
Module: serial_out_16b

---
 rtl/serial_out_pkg.sv | 16 +
 rtl/shift_reg_16b.sv | 30 +++
 rtl/serial_out_16b.sv | 114 +++++++++++
 tb/tb_serial_out_16b.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_out_pkg.sv
// rtl/serial_out_pkg.sv - shared state encoding and default width for serial_out_16b
// Optional parity build: SERIAL_OUT_PARITY_EN
package serial_out_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
`ifdef SERIAL_OUT_PARITY_EN
      ST_PARITY = 2'd2,
`endif
      ST_DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/shift_reg_16b.sv
// rtl/shift_reg_16b.sv - parallel-load, shift-left register with zero fill
// Exposes only the MSB, which is the next serial bit
module shift_reg_16b
   import serial_out_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic             msb
);

   logic [WIDTH-1:0] q;

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end else if (shift) begin
         q <= {q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_out_16b.sv
// rtl/serial_out_16b.sv - MSB-first serializer with load handshake and done pulse
// Optional even-parity trailer bit: SERIAL_OUT_PARITY_EN
module serial_out_16b
   import serial_out_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load_en;
   logic             shift_en;
   logic             sr_msb;
`ifdef SERIAL_OUT_PARITY_EN
   logic             parity_q;
`endif

   assign load_en  = (state == ST_IDLE) && load_valid;
   assign shift_en = (state == ST_SHIFT);

   shift_reg_16b #(.WIDTH(WIDTH)) u_shift_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load_en),
      .shift (shift_en),
      .d     (in),
      .msb   (sr_msb)
   );

   // sout is decoded from registered state so the first bit lands one cycle after the load edge
   always_comb begin
      sout = 1'b0;
      case (state)
         ST_SHIFT:  sout = sr_msb;
`ifdef SERIAL_OUT_PARITY_EN
         ST_PARITY: sout = parity_q;
`endif
         default:   sout = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         load_ready <= 1'b1;
         sout_valid <= 1'b0;
         done       <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_valid) begin
                  state      <= ST_SHIFT;
                  cnt        <= '0;
                  load_ready <= 1'b0;
                  sout_valid <= 1'b1;
`ifdef SERIAL_OUT_PARITY_EN
                  parity_q   <= ^in;
`endif
               end
            end
            ST_SHIFT: begin
               if (cnt == LAST_BIT) begin
                  cnt <= '0;
`ifdef SERIAL_OUT_PARITY_EN
                  state <= ST_PARITY;
`else
                  state      <= ST_DONE;
                  sout_valid <= 1'b0;
                  done       <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef SERIAL_OUT_PARITY_EN
            ST_PARITY: begin
               state      <= ST_DONE;
               sout_valid <= 1'b0;
               done       <= 1'b1;
            end
`endif
            ST_DONE: begin
               state      <= ST_IDLE;
               done       <= 1'b0;
               load_ready <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               cnt        <= '0;
               load_ready <= 1'b1;
               sout_valid <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_out_16b.sv
// tb/tb_serial_out_16b.sv - directed scoreboard bench for serial_out_16b
// Honours SERIAL_OUT_PARITY_EN to expect the trailing parity bit
module tb_serial_out_16b;

   localparam int WIDTH = 16;
`ifdef SERIAL_OUT_PARITY_EN
   localparam int NBITS = WIDTH + 1;
`else
   localparam int NBITS = WIDTH;
`endif
   localparam int PERIOD = NBITS + 2;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] in;
   logic             load_valid;
   logic             load_ready;
   logic             sout;
   logic             sout_valid;
   logic             done;

   int   vectors = 0;
   int   miscompares = 0;
   logic exp_q[$];
   int   ndone;
   int   dcyc[3];

   always #5 clk = ~clk;

   serial_out_16b #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .sout       (sout),
      .sout_valid (sout_valid),
      .done       (done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef SERIAL_OUT_PARITY_EN
      exp_q.push_back(^w);
`endif
   endtask

   task automatic check_bit(input string tag);
      check({tag, "_qlen"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check({tag, "_bit"}, 32'(sout), 32'(exp_q.pop_front()));
   endtask

   // Leaves the bench at the negedge of the first SHIFT cycle
   task automatic load_word(input string tag, input logic [WIDTH-1:0] w);
      @(negedge clk);
      check({tag, "_ready_idle"}, 32'(load_ready), 1);
      check({tag, "_sout_idle"}, 32'(sout), 0);
      in = w;
      load_valid = 1'b1;
      push_word(w);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic drain(input string tag, input bit noise);
      int nd;
      int nbits;
      nd = 0;
      nbits = 0;
      for (int c = 0; c < 40 && nd == 0; c++) begin
         if (c > 0) @(negedge clk);
         if (done) begin
            nd++;
            load_valid = 1'b0;
            check({tag, "_done_valid"}, 32'(sout_valid), 0);
            check({tag, "_done_sout"}, 32'(sout), 0);
            check({tag, "_done_ready"}, 32'(load_ready), 0);
         end else begin
            check({tag, "_valid"}, 32'(sout_valid), 1);
            check({tag, "_busy"}, 32'(load_ready), 0);
            if (sout_valid) begin
               check_bit(tag);
               nbits++;
            end
            if (noise) begin
               in = WIDTH'($urandom);
               load_valid = 1'b1;
            end
         end
      end
      check({tag, "_done_count"}, 32'(nd), 1);
      check({tag, "_nbits"}, 32'(nbits), 32'(NBITS));
      check({tag, "_qempty"}, 32'(exp_q.size()), 0);
      @(negedge clk);
      check({tag, "_ready_back"}, 32'(load_ready), 1);
      check({tag, "_done_once"}, 32'(done), 0);
      check({tag, "_idle_valid"}, 32'(sout_valid), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      load_valid = 1'b0;
      in = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(load_ready), 1);
      check("rst_sout", 32'(sout), 0);
      check("rst_valid", 32'(sout_valid), 0);
      check("rst_done", 32'(done), 0);
      reset = 1'b0;

      // Basic pattern, then parity-sensitive words
      load_word("acac", 16'b1010110010101100);
      drain("acac", 1'b0);
      load_word("w0001", 16'h0001);
      drain("w0001", 1'b0);
      load_word("w8000", 16'h8000);
      drain("w8000", 1'b0);

      // Input churn and extra load requests during SHIFT must be ignored
      load_word("ffff", 16'hFFFF);
      drain("ffff", 1'b1);
      @(negedge clk);
      check("ffff_no_recapture", 32'(sout_valid), 0);

      // Reset in the fifth SHIFT cycle aborts the word with no done pulse
      load_word("abort", 16'h5A3C);
      for (int c = 0; c < 4; c++) begin
         check_bit("abort");
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_sout", 32'(sout), 0);
      check("abort_valid", 32'(sout_valid), 0);
      check("abort_ready", 32'(load_ready), 1);
      check("abort_done", 32'(done), 0);
      exp_q.delete();
      ndone = 0;
      repeat (30) begin
         @(negedge clk);
         if (done || sout_valid) ndone++;
      end
      check("abort_no_done", 32'(ndone), 0);

      // Continuous load_valid: back-to-back words at the minimum period
      repeat (3) push_word(16'h8001);
      @(negedge clk);
      in = 16'h8001;
      load_valid = 1'b1;
      ndone = 0;
      for (int c = 1; c <= 3 * PERIOD + 10 && ndone < 3; c++) begin
         @(negedge clk);
         if (sout_valid) check_bit("stream");
         if (done) begin
            dcyc[ndone] = c;
            ndone++;
            if (ndone == 3) load_valid = 1'b0;
         end
      end
      check("stream_done_count", 32'(ndone), 3);
      check("stream_first_done", 32'(dcyc[0]), 32'(NBITS + 1));
      check("stream_period_1", 32'(dcyc[1] - dcyc[0]), 32'(PERIOD));
      check("stream_period_2", 32'(dcyc[2] - dcyc[1]), 32'(PERIOD));
      check("stream_qempty", 32'(exp_q.size()), 0);
      repeat (2) @(negedge clk);
      check("stream_stopped", 32'(sout_valid), 0);

      // Reset wins over a simultaneous load request
      @(negedge clk);
      reset = 1'b1;
      load_valid = 1'b1;
      in = 16'hFFFF;
      @(negedge clk);
      reset = 1'b0;
      load_valid = 1'b0;
      check("rst_vs_load_valid", 32'(sout_valid), 0);
      check("rst_vs_load_ready", 32'(load_ready), 1);
      @(negedge clk);
      check("rst_vs_load_idle", 32'(sout_valid), 0);
      check("rst_vs_load_sout", 32'(sout), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
